// File: rtl/register_file.sv
// Architectural register file x0-x31 with per-register ROB producer tags.
// Takes commits from the reorder buffer and renames from the instruction unit,
// and resolves both source operands in the same cycle they are presented.
module register_file #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 clear,
  input  logic                 regUpdateValid,
  input  logic [4:0]           regUpdateDest,
  input  logic [31:0]          regValue,
  input  logic [ROB_WIDTH-1:0] regUpdateRobId,
  input  logic                 renameValid,
  input  logic [4:0]           renameDest,
  input  logic [ROB_WIDTH-1:0] renameRobId,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic [ROB_WIDTH-1:0] rs1Dep,
  output logic [ROB_WIDTH-1:0] rs2Dep,
  input  logic                 robRs1Ready,
  input  logic [31:0]          robRs1Value,
  input  logic                 robRs2Ready,
  input  logic [31:0]          robRs2Value,
  output logic                 rs1Ready,
  output logic [31:0]          rs1Value,
  output logic [ROB_WIDTH-1:0] rs1Tag,
  output logic                 rs2Ready,
  output logic [31:0]          rs2Value,
  output logic [ROB_WIDTH-1:0] rs2Tag
);

  logic [31:0]          value_q [32];
  logic [31:0]          value_d [32];
  logic [31:0]          busy_q;
  logic [31:0]          busy_d;
  logic [ROB_WIDTH-1:0] dep_q   [32];
  logic [ROB_WIDTH-1:0] dep_d   [32];

  logic commit_en;
  logic rename_en;

  // x0 is never written, so its value/busy/dep stay at their reset zeros.
  assign commit_en = regUpdateValid && (regUpdateDest != 5'd0);
  assign rename_en = renameValid && (renameDest != 5'd0) && !clear;

  // Next state: commit first, then flush, then rename (rename overrides commit).
  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    dep_d   = dep_q;
    if (commit_en) begin
      value_d[regUpdateDest] = regValue;
      // Only the youngest producer may release the register; stale commits keep it busy.
      if (dep_q[regUpdateDest] == regUpdateRobId) begin
        busy_d[regUpdateDest] = 1'b0;
      end
    end
    if (clear) begin
      busy_d = '0;
    end
    if (rename_en) begin
      busy_d[renameDest] = 1'b1;
      dep_d[renameDest]  = renameRobId;
    end
  end

  // State registers with asynchronous reset that discards every pending tag.
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      value_q <= '{default: '0};
      busy_q  <= '0;
      dep_q   <= '{default: '0};
    end else begin
      value_q <= value_d;
      busy_q  <= busy_d;
      dep_q   <= dep_d;
    end
  end

  // Operand 1 resolution: x0, commit bypass, architectural value, else ROB.
  always_comb begin
    rs1Dep   = dep_q[rs1];
    rs1Ready = 1'b1;
    rs1Value = '0;
    rs1Tag   = '0;
    if (rs1 != 5'd0) begin
      if (regUpdateValid && (regUpdateDest == rs1) &&
          (!busy_q[rs1] || (dep_q[rs1] == regUpdateRobId))) begin
        rs1Value = regValue;
      end else if (!busy_q[rs1]) begin
        rs1Value = value_q[rs1];
      end else begin
        rs1Tag   = dep_q[rs1];
        rs1Ready = robRs1Ready;
        rs1Value = robRs1Value;
      end
    end
  end

  // Operand 2 resolution, identical priority to operand 1.
  always_comb begin
    rs2Dep   = dep_q[rs2];
    rs2Ready = 1'b1;
    rs2Value = '0;
    rs2Tag   = '0;
    if (rs2 != 5'd0) begin
      if (regUpdateValid && (regUpdateDest == rs2) &&
          (!busy_q[rs2] || (dep_q[rs2] == regUpdateRobId))) begin
        rs2Value = regValue;
      end else if (!busy_q[rs2]) begin
        rs2Value = value_q[rs2];
      end else begin
        rs2Tag   = dep_q[rs2];
        rs2Ready = robRs2Ready;
        rs2Value = robRs2Value;
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: directed scenarios plus random traffic,
// checked against an array-based model of architectural values and pending producers.
module tb_register_file;
  localparam int RW = 4;

  logic          clockIn = 1'b0;
  logic          resetIn = 1'b0;
  logic          clear = 1'b0;
  logic          regUpdateValid = 1'b0;
  logic [4:0]    regUpdateDest = '0;
  logic [31:0]   regValue = '0;
  logic [RW-1:0] regUpdateRobId = '0;
  logic          renameValid = 1'b0;
  logic [4:0]    renameDest = '0;
  logic [RW-1:0] renameRobId = '0;
  logic [4:0]    rs1 = '0;
  logic [4:0]    rs2 = '0;
  logic [RW-1:0] rs1Dep, rs2Dep;
  logic          robRs1Ready = 1'b0;
  logic [31:0]   robRs1Value = '0;
  logic          robRs2Ready = 1'b0;
  logic [31:0]   robRs2Value = '0;
  logic          rs1Ready, rs2Ready;
  logic [31:0]   rs1Value, rs2Value;
  logic [RW-1:0] rs1Tag, rs2Tag;

  register_file #(.ROB_WIDTH(RW)) dut (
    .clockIn(clockIn), .resetIn(resetIn), .clear(clear),
    .regUpdateValid(regUpdateValid), .regUpdateDest(regUpdateDest),
    .regValue(regValue), .regUpdateRobId(regUpdateRobId),
    .renameValid(renameValid), .renameDest(renameDest), .renameRobId(renameRobId),
    .rs1(rs1), .rs2(rs2), .rs1Dep(rs1Dep), .rs2Dep(rs2Dep),
    .robRs1Ready(robRs1Ready), .robRs1Value(robRs1Value),
    .robRs2Ready(robRs2Ready), .robRs2Value(robRs2Value),
    .rs1Ready(rs1Ready), .rs1Value(rs1Value), .rs1Tag(rs1Tag),
    .rs2Ready(rs2Ready), .rs2Value(rs2Value), .rs2Tag(rs2Tag)
  );

  always #5 clockIn = ~clockIn;

  typedef struct {
    logic          rst, clr;
    logic          cv;
    logic [4:0]    cd;
    logic [31:0]   cval;
    logic [RW-1:0] cid;
    logic          rv;
    logic [4:0]    rd;
    logic [RW-1:0] rid;
    logic [4:0]    r1, r2;
    logic          rob1_rdy, rob2_rdy;
    logic [31:0]   rob1_val, rob2_val;
  } stim_t;

  typedef struct {
    logic          rdy;
    logic [31:0]   val;
    logic [RW-1:0] tag;
    logic          chkdep;
    logic [RW-1:0] dep;
  } opnd_t;

  typedef struct {
    opnd_t o1, o2;
  } exp_t;

  // Reference model: committed values and which ROB entry (if any) still owes each register.
  logic [31:0]   arch_val [32];
  logic          pending  [32];
  logic [RW-1:0] producer [32];

  exp_t exp_q[$];
  event ev_sample;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      arch_val[i] = '0;
      pending[i]  = 1'b0;
      producer[i] = '0;
    end
  endfunction

  function automatic opnd_t model_read(input logic [4:0] r, input logic rob_rdy,
                                       input logic [31:0] rob_val, input stim_t s);
    opnd_t o;
    o.rdy = 1'b1; o.val = '0; o.tag = '0;
    o.chkdep = (r == 5'd0) || pending[r];
    o.dep = (r == 5'd0) ? '0 : producer[r];
    if (r == 5'd0) begin
      o.val = '0;
    end else if (s.cv && s.cd == r && (!pending[r] || producer[r] == s.cid)) begin
      o.val = s.cval;
    end else if (!pending[r]) begin
      o.val = arch_val[r];
    end else begin
      o.rdy = rob_rdy;
      o.val = rob_val;
      o.tag = producer[r];
    end
    return o;
  endfunction

  function automatic void model_edge(input stim_t s);
    if (s.cv && s.cd != 5'd0) begin
      arch_val[s.cd] = s.cval;
      if (pending[s.cd] && producer[s.cd] == s.cid) pending[s.cd] = 1'b0;
    end
    if (s.clr) begin
      for (int i = 0; i < 32; i++) pending[i] = 1'b0;
    end else if (s.rv && s.rd != 5'd0) begin
      pending[s.rd]  = 1'b1;
      producer[s.rd] = s.rid;
    end
  endfunction

  // One cycle: drive after the falling edge, queue the expected operands, then advance the model.
  task automatic step(input stim_t s);
    exp_t e;
    @(negedge clockIn);
    resetIn = s.rst; clear = s.clr;
    regUpdateValid = s.cv; regUpdateDest = s.cd; regValue = s.cval; regUpdateRobId = s.cid;
    renameValid = s.rv; renameDest = s.rd; renameRobId = s.rid;
    rs1 = s.r1; rs2 = s.r2;
    robRs1Ready = s.rob1_rdy; robRs1Value = s.rob1_val;
    robRs2Ready = s.rob2_rdy; robRs2Value = s.rob2_val;
    if (s.rst) model_reset();
    #1;
    e.o1 = model_read(s.r1, s.rob1_rdy, s.rob1_val, s);
    e.o2 = model_read(s.r2, s.rob2_rdy, s.rob2_val, s);
    exp_q.push_back(e);
    -> ev_sample;
    #1;
    if (!s.rst) model_edge(s);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Monitor: whenever a sample is announced, pop the expected operands and compare.
  initial begin
    exp_t e;
    forever begin
      @(ev_sample);
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
      end else begin
        e = exp_q.pop_front();
        chk("rs1Ready", {31'd0, rs1Ready}, {31'd0, e.o1.rdy});
        chk("rs1Value", rs1Value, e.o1.val);
        chk("rs1Tag", {28'd0, rs1Tag}, {28'd0, e.o1.tag});
        if (e.o1.chkdep) chk("rs1Dep", {28'd0, rs1Dep}, {28'd0, e.o1.dep});
        chk("rs2Ready", {31'd0, rs2Ready}, {31'd0, e.o2.rdy});
        chk("rs2Value", rs2Value, e.o2.val);
        chk("rs2Tag", {28'd0, rs2Tag}, {28'd0, e.o2.tag});
        if (e.o2.chkdep) chk("rs2Dep", {28'd0, rs2Dep}, {28'd0, e.o2.dep});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog at %0t: got timeout expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    model_reset();

    s = idle(); s.rst = 1'b1; s.r1 = 5'd5; s.r2 = 5'd31; step(s);
    s = idle(); s.r1 = 5'd5; s.r2 = 5'd31; step(s);

    // rename x3 -> 7, then wait on ROB, then ROB supplies the value
    s = idle(); s.rv = 1'b1; s.rd = 5'd3; s.rid = 4'd7; s.r1 = 5'd3; step(s);
    s = idle(); s.r1 = 5'd3; step(s);
    s = idle(); s.r1 = 5'd3; s.rob1_rdy = 1'b1; s.rob1_val = 32'h55; step(s);
    // commit x3 = DEAD with tag 7: bypass then architectural
    s = idle(); s.cv = 1'b1; s.cd = 5'd3; s.cval = 32'hDEAD; s.cid = 4'd7; s.r1 = 5'd3; step(s);
    s = idle(); s.r1 = 5'd3; s.r2 = 5'd3; step(s);

    // two renames of x4; stale commit keeps it busy on the newer tag
    s = idle(); s.rv = 1'b1; s.rd = 5'd4; s.rid = 4'd2; step(s);
    s = idle(); s.rv = 1'b1; s.rd = 5'd4; s.rid = 4'd5; step(s);
    s = idle(); s.cv = 1'b1; s.cd = 5'd4; s.cval = 32'h11; s.cid = 4'd2; s.r1 = 5'd4; s.r2 = 5'd4;
    s.rob2_rdy = 1'b1; s.rob2_val = 32'hABCD; step(s);
    s = idle(); s.r1 = 5'd4; step(s);
    s = idle(); s.cv = 1'b1; s.cd = 5'd4; s.cval = 32'h22; s.cid = 4'd5; s.r1 = 5'd4; step(s);
    s = idle(); s.r1 = 5'd4; step(s);

    // same-cycle commit and rename of x6
    s = idle(); s.cv = 1'b1; s.cd = 5'd6; s.cval = 32'h66; s.cid = 4'd1;
    s.rv = 1'b1; s.rd = 5'd6; s.rid = 4'd9; s.r1 = 5'd6; step(s);
    s = idle(); s.r1 = 5'd6; s.r2 = 5'd6; s.rob2_rdy = 1'b1; s.rob2_val = 32'h1234; step(s);
    s = idle(); s.cv = 1'b1; s.cd = 5'd9; s.cval = 32'h99; s.cid = 4'd0; step(s);

    // flush with concurrent commit and dropped rename
    s = idle(); s.rv = 1'b1; s.rd = 5'd8; s.rid = 4'd3; step(s);
    s = idle(); s.rv = 1'b1; s.rd = 5'd9; s.rid = 4'd4; s.r1 = 5'd9; step(s);
    s = idle(); s.clr = 1'b1; s.cv = 1'b1; s.cd = 5'd8; s.cval = 32'h77; s.cid = 4'd3;
    s.rv = 1'b1; s.rd = 5'd10; s.rid = 4'd6; step(s);
    s = idle(); s.r1 = 5'd8; s.r2 = 5'd9; step(s);
    s = idle(); s.r1 = 5'd10; step(s);

    // x0 ignores writes and renames
    s = idle(); s.cv = 1'b1; s.cd = 5'd0; s.cval = 32'hFFFF_FFFF; s.cid = 4'd0;
    s.rv = 1'b1; s.rd = 5'd0; s.rid = 4'd1; s.r1 = 5'd0; s.r2 = 5'd0; step(s);
    s = idle(); s.r1 = 5'd0; s.r2 = 5'd0; step(s);

    // random traffic, with a reset asserted between edges partway through
    for (int n = 0; n < 400; n++) begin
      s = idle();
      if (n == 200) begin
        s.rst = 1'b1; s.r1 = 5'd3; s.r2 = 5'd6;
      end else begin
        s.r1 = 5'($urandom_range(0, 7));
        s.r2 = 5'($urandom_range(0, 7));
        s.rob1_rdy = 1'($urandom_range(0, 1)); s.rob1_val = $urandom;
        s.rob2_rdy = 1'($urandom_range(0, 1)); s.rob2_val = $urandom;
        if ($urandom_range(0, 2) == 0) begin
          s.cv = 1'b1;
          s.cd = 5'($urandom_range(0, 7));
          s.cval = $urandom;
          if (pending[s.cd] && $urandom_range(0, 1) == 1) s.cid = producer[s.cd];
          else s.cid = RW'($urandom_range(0, 15));
        end
        if ($urandom_range(0, 2) == 0) begin
          s.rv = 1'b1;
          s.rd = 5'($urandom_range(0, 7));
          s.rid = RW'($urandom_range(0, 15));
        end
        s.clr = ($urandom_range(0, 15) == 0);
      end
      step(s);
    end

    s = idle(); step(s);
    #20;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
